// File: rtl/dp_rr_sched.sv
// dp_rr_sched: round-robin scheduler that shares a single adder datapath
// among NREQ requesters.
//
// A pending request is picked round-robin from ptr. The winner's operands
// are latched into dp_d1/dp_d2 and dp_start is raised. All of these are held
// until dp_done arrives. The result then goes back on d_out together with a
// one-cycle ack to the winner.
//
// Ports:
//   clka      : system clock, all logic on posedge
//   restart   : synchronous active-high reset
//   req       : per-requester level request, held until ack
//   d1_in     : packed operand A, slice i belongs to requester i
//   d2_in     : packed operand B, slice i belongs to requester i
//   gnt       : one-hot grant, high from WAIT through RESP
//   ack       : one-hot, one-cycle result-valid pulse
//   d_out     : result for the acked requester, held until the next ack
//   busy      : high whenever the FSM is not IDLE
//   dp_start  : datapath start, held through WAIT
//   dp_d1     : registered datapath operand A
//   dp_d2     : registered datapath operand B
//   dp_dout   : datapath result
//   dp_done   : datapath completion
//   err       : (DP_TIMEOUT_EN only) timeout abort flag, high in the RESP cycle
//
// Build option: define DP_TIMEOUT_EN to add the err output and the WAIT
// timeout counter. Without it, WAIT persists until dp_done or restart.

module dp_rr_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clka,
    input  logic                    restart,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   d1_in,
    input  logic [NREQ*WIDTH-1:0]   d2_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        d_out,
    output logic                    busy,
    output logic                    dp_start,
    output logic [WIDTH-1:0]        dp_d1,
    output logic [WIDTH-1:0]        dp_d2,
    input  logic [WIDTH-1:0]        dp_dout,
`ifdef DP_TIMEOUT_EN
    input  logic                    dp_done,
    output logic                    err
`else
    input  logic                    dp_done
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    logic            found;
    int unsigned     idx;

`ifdef DP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt;
`endif

    // Scan ptr, ptr+1, ... (mod NREQ). The first set request wins.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx  = (32'(ptr) + i) % NREQ;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clka) begin
        if (restart) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            gnt      <= '0;
            ack      <= '0;
            d_out    <= '0;
            dp_start <= 1'b0;
            dp_d1    <= '0;
            dp_d2    <= '0;
`ifdef DP_TIMEOUT_EN
            cnt      <= '0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win      <= pick;
                        gnt      <= NREQ'(1) << pick;
                        dp_d1    <= d1_in[pick*WIDTH +: WIDTH];
                        dp_d2    <= d2_in[pick*WIDTH +: WIDTH];
                        dp_start <= 1'b1;
                        state    <= WAIT;
`ifdef DP_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (dp_done) begin
                        d_out    <= dp_dout;
                        ack      <= gnt;
                        dp_start <= 1'b0;
                        state    <= RESP;
`ifdef DP_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Abort after TIMEOUT full WAIT cycles without dp_done.
                        d_out    <= '0;
                        ack      <= gnt;
                        err      <= 1'b1;
                        dp_start <= 1'b0;
                        state    <= RESP;
                    end else begin
                        cnt      <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    ack   <= '0;
                    gnt   <= '0;
                    // Served requester drops to lowest priority.
                    ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state <= IDLE;
`ifdef DP_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_rr_sched.sv
// tb_dp_rr_sched: directed self-checking bench for dp_rr_sched.
// Contains a simple adder datapath model with a programmable done delay.
// Build with DP_TIMEOUT_EN defined to exercise the timeout abort path.

module tb_dp_rr_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clka = 1'b0;
    logic                  restart;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d1_in;
    logic [NREQ*WIDTH-1:0] d2_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      d_out;
    logic                  busy;
    logic                  dp_start;
    logic [WIDTH-1:0]      dp_d1;
    logic [WIDTH-1:0]      dp_d2;
    logic [WIDTH-1:0]      dp_dout;
    logic                  dp_done;
`ifdef DP_TIMEOUT_EN
    logic                  err;
`endif

    logic [WIDTH-1:0] a [NREQ];
    logic [WIDTH-1:0] b [NREQ];

    int n_chk  = 0;
    int n_pass = 0;
    int dly    = 0;
    int dcnt   = 0;

    always #5 clka = ~clka;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            d1_in[i*WIDTH +: WIDTH] = a[i];
            d2_in[i*WIDTH +: WIDTH] = b[i];
        end
    end

    // Datapath model: adder result, done dly cycles into the start window.
    always @(posedge clka) begin
        if (!dp_start) dcnt <= 0;
        else           dcnt <= dcnt + 1;
    end
    assign dp_dout = dp_d1 + dp_d2;
    assign dp_done = dp_start && (dcnt >= dly);

    dp_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(15)) dut (
        .clka     (clka),
        .restart  (restart),
        .req      (req),
        .d1_in    (d1_in),
        .d2_in    (d2_in),
        .gnt      (gnt),
        .ack      (ack),
        .d_out    (d_out),
        .busy     (busy),
        .dp_start (dp_start),
        .dp_d1    (dp_d1),
        .dp_d2    (dp_d2),
        .dp_dout  (dp_dout),
`ifdef DP_TIMEOUT_EN
        .dp_done  (dp_done),
        .err      (err)
`else
        .dp_done  (dp_done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    initial begin
        restart = 1'b1;
        req     = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        tick();
        tick();
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_dout", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_start", dp_start, 0);
        check("rst_d1", dp_d1, 0);
        restart = 1'b0;

        // Single request: 3 + 4 = 7
        a[0] = 4'd3; b[0] = 4'd4; req = 4'b0001;
        tick();
        check("t1_gnt_wait", gnt, 4'b0001);
        check("t1_start", dp_start, 1);
        check("t1_d1", dp_d1, 3);
        check("t1_d2", dp_d2, 4);
        check("t1_busy", busy, 1);
        check("t1_ack_wait", ack, 0);
        tick();
        check("t1_ack", ack, 4'b0001);
        check("t1_dout", d_out, 7);
        check("t1_gnt_resp", gnt, 4'b0001);
        check("t1_start_resp", dp_start, 0);
        req = '0;
        tick();
        check("t1_ack_off", ack, 0);
        check("t1_gnt_off", gnt, 0);
        check("t1_idle", busy, 0);

        // Contention from ptr=0: order 0,1,2,3,0, sums i+1
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = WIDTH'(i);
            b[i] = 4'd1;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % NREQ;
            tick();
            check("t2_gnt", gnt, 32'(1) << w);
            tick();
            check("t2_ack", ack, 32'(1) << w);
            check("t2_dout", d_out, w + 1);
            if (k == 4) req = '0;
            tick();
            check("t2_gap", ack, 0);
        end

        // Wrap: ptr=1, only req3 -> 9+9 wraps to 2, ptr returns to 0
        a[3] = 4'd9; b[3] = 4'd9; req = 4'b1000;
        tick();
        check("t3_gnt", gnt, 4'b1000);
        tick();
        check("t3_ack", ack, 4'b1000);
        check("t3_dout", d_out, 2);
        a[0] = 4'd2; b[0] = 4'd5; req = 4'b0011;
        tick();
        check("t3_idle_gnt", gnt, 0);
        tick();
        check("t3_wrap_gnt", gnt, 4'b0001);
        tick();
        check("t3_wrap_dout", d_out, 7);
        req = '0;
        tick();

        // Restart mid-WAIT: ptr=1, req1 granted then aborted
        dly = 1000; req = 4'b0010;
        tick();
        check("t4_gnt", gnt, 4'b0010);
        tick();
        check("t4_hold", dp_start, 1);
        restart = 1'b1;
        tick();
        check("t4_start", dp_start, 0);
        check("t4_gnt_clr", gnt, 0);
        check("t4_ack", ack, 0);
        check("t4_busy", busy, 0);
        check("t4_dout", d_out, 0);
        restart = 1'b0; req = '0;
        tick();
        check("t4_noack", ack, 0);
        dly = 0; req = 4'b0011;
        tick();
        check("t4_ptr0", gnt, 4'b0001);
        tick();
        check("t4_ack2", ack, 4'b0001);
        req = '0;
        tick();

        // Drop req during WAIT: ptr=1, req2, done in 4th WAIT cycle
        a[2] = 4'd5; b[2] = 4'd6; dly = 3; req = 4'b0100;
        tick();
        check("t5_gnt", gnt, 4'b0100);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_wait", ack, 0);
        end
        tick();
        check("t5_ack", ack, 4'b0100);
        check("t5_dout", d_out, 11);
        tick();
        req = 4'b1001; dly = 0;
        tick();
        check("t5_ptr3", gnt, 4'b1000);
        tick();
        check("t5_dout2", d_out, 2);
        req = '0;
        tick();

        // Stuck datapath
        dly = 1000; req = 4'b0001;
        tick();
        check("t6_gnt", gnt, 4'b0001);
        req = '0;
`ifdef DP_TIMEOUT_EN
        for (int k = 0; k < 14; k++) begin
            tick();
            check("t6_wait_ack", ack, 0);
            check("t6_wait_err", err, 0);
        end
        tick();
        check("t6_to_ack", ack, 4'b0001);
        check("t6_to_err", err, 1);
        check("t6_to_dout", d_out, 0);
        tick();
        check("t6_err_off", err, 0);
        check("t6_idle", busy, 0);
`else
        for (int k = 0; k < 30; k++) tick();
        check("t6_busy", busy, 1);
        check("t6_noack", ack, 0);
        check("t6_start", dp_start, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t6_rst", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
